glob_desc_fetch: RTL and testbench
==================================

// Module: glob_desc_fetch
// PURPOSE
//  Fetches an 8-byte segment descriptor from GDT/LDT for a selector and loads it into the global
//  register file as glob_descriptor or glob_descriptor_2. Performs the selector table-limit check,
//  assembles the descriptor from two dword reads and pulses the *_set strobes consumed by global_regs.
//  Sits between the microcode/exception path (requester) and global_regs plus the memory read port.
// PARAMETERS
//  NULL_CHECK  1    1: GDT selector with index 0 faults (code 0); 0: null selector is fetched normally
//  RD_TIMEOUT  255  cycles a dword read may wait for rd_done before timeout fault; 0 disables timeout
// PORTS
//  clk                      in   1   clock
//  rst_n                    in   1   reset, asynchronous, active-low
//  req                      in   1   fetch request; accepted only when busy=0
//  req_selector             in   16  selector: [15:3] index, [2] TI (1=LDT), [1:0] RPL
//  req_target               in   1   0: load glob_descriptor, 1: load glob_descriptor_2
//  abort                    in   1   pipeline flush; cancels fetch in progress
//  gdtr_base / gdtr_limit   in   32/16  GDT base and byte limit
//  ldtr_base / ldtr_limit   in   32/32  LDT base and byte limit
//  ldtr_valid               in   1   LDTR holds a usable LDT
//  rd_req                   out  1   dword read request, held until rd_done
//  rd_addr                  out  32  read address
//  rd_done                  in   1   single-cycle read completion; rd_data valid same cycle
//  rd_data                  in   32  read data
//  busy                     out  1   state != IDLE
//  done                     out  1   one-cycle pulse: descriptor loaded
//  fault                    out  1   one-cycle pulse: fetch failed, nothing loaded
//  fault_code               out  16  error code, valid with fault, held until next fault
//  glob_descriptor_set      out  1   one-cycle load strobe (req_target=0)
//  glob_descriptor_2_set    out  1   one-cycle load strobe (req_target=1)
//  glob_descriptor_value    out  64  {hi,lo} descriptor; drives both *_value inputs of global_regs
//  glob_param_1_set         out  1   one-cycle strobe with done
//  glob_param_1_value       out  32  {16'd0, latched selector}
// BEHAVIOUR
//  Reset: state=IDLE; all outputs 0 (rd_addr, fault_code, glob_descriptor_value, param value = 0).
//  States: IDLE -> CHK -> RD_LO -> RD_HI -> LOAD -> IDLE; CHK/RD_LO/RD_HI -> FAULT -> IDLE.
//  IDLE: req & !abort latches selector, target, table base/limit (TI selects LDT vs GDT); -> CHK.
//  CHK (1 cycle): off = {16'd0, index, 3'b000}; fault if TI=1 & !ldtr_valid, or off+7 > limit
//   (33-bit compare, no wrap), or NULL_CHECK & TI=0 & index=0. Else addr = base+off mod 2^32 -> RD_LO.
//  RD_LO: rd_req=1, rd_addr=addr; on rd_done capture lo=rd_data -> RD_HI. RD_HI: rd_addr=addr+4
//   (mod 2^32); on rd_done capture hi -> LOAD. rd_req drops for exactly 0 cycles between reads
//   only if implementation prefers; minimum requirement: rd_addr stable while rd_req=1.
//  LOAD (1 cycle): target strobe, glob_param_1_set and done all =1; value = {hi,lo}. -> IDLE.
//  Latency, zero-wait memory (rd_done in first request cycle): req at cycle 0 -> done at cycle 4.
//  FAULT (1 cycle): fault=1; fault_code = {sel[15:3],TI,2'b00} for limit/LDT fault, 16'h0000 for
//   null, 16'hFFFF for timeout. No set strobe. -> IDLE.
//  Timeout: per-read counter cleared on entry to RD_LO/RD_HI; reaching RD_TIMEOUT w/o rd_done -> FAULT.
//  abort: highest priority in any state; next state IDLE, rd_req deasserts next cycle, no strobe,
//   no done/fault. abort with rd_done same cycle: data discarded. abort & req in IDLE: req ignored.
//  rd_done while not in RD_LO/RD_HI: ignored. req while busy: ignored (requester waits on busy=0).
//  Reset mid-fetch: immediate return to IDLE, all outputs 0, no strobe.
// TESTING
//  GDT base 0x1000 limit 0x27, sel 0x0010, target 0, zero-wait mem lo=0x0000FFFF hi=0x00CF9A00
//   -> rd_addr 0x1010 then 0x1014; cycle 4: glob_descriptor_set, value 0x00CF9A000000FFFF, param 0x10.
//  GDT limit 0x17, sel 0x0018 -> fault at cycle 2, fault_code 0x0018, no rd_req, no set strobes.
//  sel 0x0000, NULL_CHECK=1 -> fault, code 0x0000; sel 0x000C with ldtr_valid=0 -> fault, code 0x000C.
//  LDT base 0xFFFFFFF8 limit 0xF, sel 0x0004 target 1 -> reads 0xFFFFFFF8 then 0xFFFFFFFC;
//   glob_descriptor_2_set pulses; base 0xFFFFFFFC, sel 0x0004 -> second read wraps to 0x00000000.
//  rd_done withheld RD_TIMEOUT=4 cycles in RD_HI -> fault code 0xFFFF; abort asserted in RD_LO with
//   rd_done same cycle -> IDLE, no done/fault/strobe, next req accepted normally.

Source files
------------

// File: rtl/glob_desc_fetch_if.sv
// Bundle between glob_desc_fetch, its requester, the memory read port and global_regs.
// slave = the fetch engine; master = the surrounding environment.
interface glob_desc_fetch_if;
    logic        req;
    logic [15:0] req_selector;
    logic        req_target;
    logic        abort;
    logic [31:0] gdtr_base;
    logic [15:0] gdtr_limit;
    logic [31:0] ldtr_base;
    logic [31:0] ldtr_limit;
    logic        ldtr_valid;
    logic        rd_req;
    logic [31:0] rd_addr;
    logic        rd_done;
    logic [31:0] rd_data;
    logic        busy;
    logic        done;
    logic        fault;
    logic [15:0] fault_code;
    logic        glob_descriptor_set;
    logic        glob_descriptor_2_set;
    logic [63:0] glob_descriptor_value;
    logic        glob_param_1_set;
    logic [31:0] glob_param_1_value;

    modport slave (
        input  req, req_selector, req_target, abort,
        input  gdtr_base, gdtr_limit, ldtr_base, ldtr_limit, ldtr_valid,
        input  rd_done, rd_data,
        output rd_req, rd_addr, busy, done, fault, fault_code,
        output glob_descriptor_set, glob_descriptor_2_set, glob_descriptor_value,
        output glob_param_1_set, glob_param_1_value
    );

    modport master (
        output req, req_selector, req_target, abort,
        output gdtr_base, gdtr_limit, ldtr_base, ldtr_limit, ldtr_valid,
        output rd_done, rd_data,
        input  rd_req, rd_addr, busy, done, fault, fault_code,
        input  glob_descriptor_set, glob_descriptor_2_set, glob_descriptor_value,
        input  glob_param_1_set, glob_param_1_value
    );
endinterface

// File: rtl/glob_desc_fetch.sv
// Segment descriptor fetch: selector limit check, two dword reads, load strobes into global_regs.
// Latency: req -> done in 4 cycles with zero-wait memory; each read stretches by its wait states.
// Backpressure: req taken only while busy=0; rd_req/rd_addr held until rd_done, timeout or abort.
module glob_desc_fetch #(
    parameter bit          NULL_CHECK = 1'b1,
    parameter int unsigned RD_TIMEOUT = 255
) (
    input  logic             clk,
    input  logic             rst_n,
    glob_desc_fetch_if.slave bus
);
    localparam int unsigned CW = (RD_TIMEOUT > 1) ? $clog2(RD_TIMEOUT + 1) : 1;

    typedef enum logic [2:0] {
        S_IDLE, S_CHK, S_RD_LO, S_RD_HI, S_LOAD, S_FAULT
    } state_t;

    state_t         state_q, state_d;
    logic [15:0]    sel_q, sel_d;
    logic           tgt_q, tgt_d;
    logic [31:0]    base_q, base_d;
    logic [31:0]    limit_q, limit_d;
    logic [31:0]    addr_q, addr_d;
    logic [31:0]    lo_q, lo_d;
    logic [31:0]    hi_q, hi_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [15:0]    fault_code_q, fault_code_d;

    logic           rd_req, done, fault, set_0, set_1, param_set;
    logic [31:0]    rd_addr;
    logic [31:0]    off;
    logic           lim_exceed;
    logic           timeout_hit;

    assign off         = {16'd0, sel_q[15:3], 3'b000};
    // 33-bit compare so offsets near the top of a 4 GiB LDT limit cannot wrap past it
    assign lim_exceed  = ({1'b0, off} + 33'd7) > {1'b0, limit_q};
    assign timeout_hit = (RD_TIMEOUT != 0) && ((32'(cnt_q) + 32'd1) == RD_TIMEOUT);

    always_comb begin
        state_d      = state_q;
        sel_d        = sel_q;
        tgt_d        = tgt_q;
        base_d       = base_q;
        limit_d      = limit_q;
        addr_d       = addr_q;
        lo_d         = lo_q;
        hi_d         = hi_q;
        cnt_d        = cnt_q;
        fault_code_d = fault_code_q;
        rd_req       = 1'b0;
        rd_addr      = 32'd0;
        done         = 1'b0;
        fault        = 1'b0;
        set_0        = 1'b0;
        set_1        = 1'b0;
        param_set    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (bus.req && !bus.abort) begin
                    sel_d   = bus.req_selector;
                    tgt_d   = bus.req_target;
                    base_d  = bus.req_selector[2] ? bus.ldtr_base  : bus.gdtr_base;
                    limit_d = bus.req_selector[2] ? bus.ldtr_limit : {16'd0, bus.gdtr_limit};
                    state_d = S_CHK;
                end
            end
            S_CHK: begin
                if (NULL_CHECK && !sel_q[2] && (sel_q[15:3] == 13'd0)) begin
                    fault_code_d = 16'h0000;
                    state_d      = S_FAULT;
                end else if ((sel_q[2] && !bus.ldtr_valid) || lim_exceed) begin
                    fault_code_d = {sel_q[15:3], sel_q[2], 2'b00};
                    state_d      = S_FAULT;
                end else begin
                    addr_d  = base_q + off;
                    cnt_d   = '0;
                    state_d = S_RD_LO;
                end
            end
            S_RD_LO: begin
                rd_req  = 1'b1;
                rd_addr = addr_q;
                if (bus.rd_done) begin
                    lo_d    = bus.rd_data;
                    cnt_d   = '0;
                    state_d = S_RD_HI;
                end else if (timeout_hit) begin
                    fault_code_d = 16'hFFFF;
                    state_d      = S_FAULT;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_RD_HI: begin
                rd_req  = 1'b1;
                rd_addr = addr_q + 32'd4;
                if (bus.rd_done) begin
                    hi_d    = bus.rd_data;
                    state_d = S_LOAD;
                end else if (timeout_hit) begin
                    fault_code_d = 16'hFFFF;
                    state_d      = S_FAULT;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_LOAD: begin
                done      = 1'b1;
                set_0     = !tgt_q;
                set_1     = tgt_q;
                param_set = 1'b1;
                state_d   = S_IDLE;
            end
            S_FAULT: begin
                fault   = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // Flush wins over everything: discard read data and suppress every result pulse
        if (bus.abort) begin
            state_d      = S_IDLE;
            lo_d         = lo_q;
            hi_d         = hi_q;
            fault_code_d = fault_code_q;
            done         = 1'b0;
            fault        = 1'b0;
            set_0        = 1'b0;
            set_1        = 1'b0;
            param_set    = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            sel_q        <= 16'd0;
            tgt_q        <= 1'b0;
            base_q       <= 32'd0;
            limit_q      <= 32'd0;
            addr_q       <= 32'd0;
            lo_q         <= 32'd0;
            hi_q         <= 32'd0;
            cnt_q        <= '0;
            fault_code_q <= 16'd0;
        end else begin
            state_q      <= state_d;
            sel_q        <= sel_d;
            tgt_q        <= tgt_d;
            base_q       <= base_d;
            limit_q      <= limit_d;
            addr_q       <= addr_d;
            lo_q         <= lo_d;
            hi_q         <= hi_d;
            cnt_q        <= cnt_d;
            fault_code_q <= fault_code_d;
        end
    end

    assign bus.rd_req                = rd_req;
    assign bus.rd_addr               = rd_addr;
    assign bus.busy                  = (state_q != S_IDLE);
    assign bus.done                  = done;
    assign bus.fault                 = fault;
    assign bus.fault_code            = fault_code_q;
    assign bus.glob_descriptor_set   = set_0;
    assign bus.glob_descriptor_2_set = set_1;
    assign bus.glob_descriptor_value = {hi_q, lo_q};
    assign bus.glob_param_1_set      = param_set;
    assign bus.glob_param_1_value    = {16'd0, sel_q};
endmodule

// File: tb/tb_glob_desc_fetch.sv
// Bench for glob_desc_fetch: directed cases followed by randomized fetches against a reference model.
module tb_glob_desc_fetch;
    localparam int TMO = 4;
    localparam int WIN = 14;

    logic clk;
    logic rst_n;
    glob_desc_fetch_if bus();

    glob_desc_fetch #(.NULL_CHECK(1'b1), .RD_TIMEOUT(TMO)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int errors = 0;
    int checks = 0;

    int lat_lo = 0;
    int lat_hi = 0;
    int rd_seq = 0;
    logic [31:0] addr_log[$];
    logic [31:0] mem_ovr[logic [31:0]];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, observed=running required=finished");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [31:0] memf(input logic [31:0] a);
        if (mem_ovr.exists(a)) return mem_ovr[a];
        return (a * 32'h9E3779B1) ^ 32'h5A5A1234;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Memory: answers the (n+1)th request cycle for an n-wait read; first read of a fetch uses lat_lo.
    initial begin
        int wait_n;
        wait_n = 0;
        bus.rd_done = 1'b0;
        bus.rd_data = 32'd0;
        forever begin
            @(posedge clk);
            #1;
            if (bus.rd_req === 1'b1) begin
                if (wait_n >= ((rd_seq == 0) ? lat_lo : lat_hi)) begin
                    bus.rd_done = 1'b1;
                    bus.rd_data = memf(bus.rd_addr);
                    addr_log.push_back(bus.rd_addr);
                    rd_seq++;
                    wait_n = 0;
                end else begin
                    bus.rd_done = 1'b0;
                    bus.rd_data = 32'hDEAD_BEEF;
                    wait_n++;
                end
            end else begin
                bus.rd_done = 1'b0;
                wait_n = 0;
            end
        end
    end

    task automatic run_fetch(input string name, input logic [15:0] sel, input logic tgt,
                             input int llo, input int lhi, input int abort_cyc, input bit noise);
        longint unsigned base, lim, off;
        int idx, ti, exp_kind, exp_cyc, n_exp;
        logic [15:0] exp_code;
        logic [31:0] a0, a1, par_seen;
        logic [63:0] exp_val, val_seen;
        logic [15:0] code_seen;
        bit exp_rd, saw_rd;
        int done_cyc, fault_cyc, n_done, n_fault, n_s0, n_s1, n_p;

        // reference model: outcome 0=none 1=done 2=fault
        idx  = int'(sel) / 8;
        ti   = (int'(sel) / 4) % 2;
        base = (ti == 1) ? longint'(bus.ldtr_base) : longint'(bus.gdtr_base);
        lim  = (ti == 1) ? longint'(bus.ldtr_limit) : longint'(bus.gdtr_limit);
        off  = longint'(idx) * 8;
        a0   = 32'((base + off) % 64'h1_0000_0000);
        a1   = 32'((longint'(a0) + 4) % 64'h1_0000_0000);
        exp_val = {memf(a1), memf(a0)};
        exp_code = 16'd0;
        exp_rd = 1'b0;
        n_exp = 0;
        if (ti == 1 && !bus.ldtr_valid) begin
            exp_kind = 2; exp_cyc = 2; exp_code = 16'(idx * 8 + 4);
        end else if (ti == 0 && idx == 0) begin
            exp_kind = 2; exp_cyc = 2; exp_code = 16'h0000;
        end else if (off + 7 > lim) begin
            exp_kind = 2; exp_cyc = 2; exp_code = 16'(idx * 8 + ti * 4);
        end else begin
            exp_rd = 1'b1;
            if (llo >= TMO) begin
                exp_kind = 2; exp_cyc = 2 + TMO; exp_code = 16'hFFFF; n_exp = 0;
            end else if (lhi >= TMO) begin
                exp_kind = 2; exp_cyc = 3 + llo + TMO; exp_code = 16'hFFFF; n_exp = 1;
            end else begin
                exp_kind = 1; exp_cyc = 4 + llo + lhi; n_exp = 2;
            end
        end
        if (abort_cyc != 0 && abort_cyc <= exp_cyc) exp_kind = 0;
        if (abort_cyc == 1) exp_rd = 1'b0;
        if (exp_cyc < 4 || abort_cyc != 0) noise = 1'b0;

        done_cyc = -1; fault_cyc = -1;
        n_done = 0; n_fault = 0; n_s0 = 0; n_s1 = 0; n_p = 0;
        val_seen = '0; par_seen = '0; code_seen = '0; saw_rd = 1'b0;
        lat_lo = llo; lat_hi = lhi; rd_seq = 0;
        addr_log.delete();

        @(negedge clk);
        bus.req = 1'b1; bus.req_selector = sel; bus.req_target = tgt;
        for (int c = 1; c <= WIN; c++) begin
            @(negedge clk);
            bus.req = (noise && c == 3);
            bus.req_selector = (noise && c == 3) ? ~sel : sel;
            bus.req_target = (noise && c == 3) ? ~tgt : tgt;
            bus.abort = (c == abort_cyc);
            #1;
            if (bus.rd_req === 1'b1) saw_rd = 1'b1;
            if (bus.done === 1'b1) begin
                n_done++;
                if (done_cyc < 0) done_cyc = c;
                val_seen = bus.glob_descriptor_value;
            end
            if (bus.fault === 1'b1) begin
                n_fault++;
                if (fault_cyc < 0) fault_cyc = c;
                code_seen = bus.fault_code;
            end
            if (bus.glob_param_1_set === 1'b1) begin
                n_p++;
                par_seen = bus.glob_param_1_value;
            end
            if (bus.glob_descriptor_set === 1'b1) n_s0++;
            if (bus.glob_descriptor_2_set === 1'b1) n_s1++;
            if (abort_cyc != 0 && c == abort_cyc + 1)
                chk({name, "/abort_idle"}, {62'd0, bus.busy, bus.rd_req}, 64'd0);
        end
        bus.req = 1'b0;
        bus.abort = 1'b0;

        chk({name, "/done_cyc"}, 64'(done_cyc), 64'((exp_kind == 1) ? exp_cyc : -1));
        chk({name, "/fault_cyc"}, 64'(fault_cyc), 64'((exp_kind == 2) ? exp_cyc : -1));
        chk({name, "/n_done"}, 64'(n_done), 64'((exp_kind == 1) ? 1 : 0));
        chk({name, "/n_fault"}, 64'(n_fault), 64'((exp_kind == 2) ? 1 : 0));
        chk({name, "/n_set0"}, 64'(n_s0), 64'((exp_kind == 1 && !tgt) ? 1 : 0));
        chk({name, "/n_set1"}, 64'(n_s1), 64'((exp_kind == 1 && tgt) ? 1 : 0));
        chk({name, "/n_param"}, 64'(n_p), 64'((exp_kind == 1) ? 1 : 0));
        chk({name, "/saw_rd"}, 64'(saw_rd), 64'(exp_rd));
        chk({name, "/busy_end"}, 64'(bus.busy), 64'd0);
        if (exp_kind == 1) begin
            chk({name, "/value"}, val_seen, exp_val);
            chk({name, "/param"}, 64'(par_seen), 64'(sel));
        end
        if (exp_kind == 2) chk({name, "/code"}, 64'(code_seen), 64'(exp_code));
        if (abort_cyc == 0) begin
            chk({name, "/n_reads"}, 64'(addr_log.size()), 64'(n_exp));
            if (n_exp >= 1 && addr_log.size() >= 1) chk({name, "/addr0"}, 64'(addr_log[0]), 64'(a0));
            if (n_exp >= 2 && addr_log.size() >= 2) chk({name, "/addr1"}, 64'(addr_log[1]), 64'(a1));
        end
    endtask

    initial begin
        int d_cnt;
        rst_n = 1'b0;
        bus.req = 1'b0; bus.req_selector = 16'd0; bus.req_target = 1'b0; bus.abort = 1'b0;
        bus.gdtr_base = 32'h1000; bus.gdtr_limit = 16'h27;
        bus.ldtr_base = 32'd0; bus.ldtr_limit = 32'd0; bus.ldtr_valid = 1'b1;
        mem_ovr[32'h1010] = 32'h0000FFFF;
        mem_ovr[32'h1014] = 32'h00CF9A00;

        repeat (3) @(negedge clk);
        chk("reset/busy", 64'(bus.busy), 64'd0);
        chk("reset/rd", {31'd0, bus.rd_req, bus.rd_addr}, 64'd0);
        chk("reset/pulses", {59'd0, bus.done, bus.fault, bus.glob_descriptor_set,
                             bus.glob_descriptor_2_set, bus.glob_param_1_set}, 64'd0);
        chk("reset/fault_code", 64'(bus.fault_code), 64'd0);
        chk("reset/value", bus.glob_descriptor_value, 64'd0);
        chk("reset/param", 64'(bus.glob_param_1_value), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        run_fetch("gdt_basic", 16'h0010, 1'b0, 0, 0, 0, 1'b0);
        bus.gdtr_limit = 16'h17;
        run_fetch("gdt_limit", 16'h0018, 1'b0, 0, 0, 0, 1'b0);
        run_fetch("gdt_null", 16'h0000, 1'b0, 0, 0, 0, 1'b0);
        bus.ldtr_valid = 1'b0;
        run_fetch("ldt_invalid", 16'h000C, 1'b0, 0, 0, 0, 1'b0);
        bus.ldtr_valid = 1'b1; bus.ldtr_base = 32'hFFFFFFF8; bus.ldtr_limit = 32'hF;
        run_fetch("ldt_top", 16'h0004, 1'b1, 0, 0, 0, 1'b0);
        bus.ldtr_base = 32'hFFFFFFFC;
        run_fetch("ldt_wrap", 16'h0004, 1'b1, 1, 2, 0, 1'b0);
        bus.gdtr_limit = 16'h27;
        run_fetch("tmo_hi", 16'h0010, 1'b0, 0, TMO, 0, 1'b0);
        run_fetch("tmo_edge", 16'h0010, 1'b0, TMO - 1, TMO - 1, 0, 1'b1);
        run_fetch("abort_rdlo", 16'h0010, 1'b0, 0, 0, 2, 1'b0);
        run_fetch("after_abort", 16'h0010, 1'b1, 0, 0, 0, 1'b0);
        run_fetch("abort_load", 16'h0010, 1'b0, 0, 0, 4, 1'b0);

        // req together with abort in IDLE must not start a fetch
        @(negedge clk);
        bus.req = 1'b1; bus.abort = 1'b1; bus.req_selector = 16'h0010;
        @(negedge clk);
        bus.req = 1'b0; bus.abort = 1'b0;
        #1;
        chk("abort_req_idle/busy", 64'(bus.busy), 64'd0);

        // reset in RD_HI: everything returns to zero at once, no later pulse
        lat_lo = 0; lat_hi = 0; rd_seq = 0;
        @(negedge clk);
        bus.req = 1'b1; bus.req_selector = 16'h0010; bus.req_target = 1'b0;
        @(negedge clk);
        bus.req = 1'b0;
        repeat (2) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_mid/busy_rd", {62'd0, bus.busy, bus.rd_req}, 64'd0);
        chk("rst_mid/value", bus.glob_descriptor_value, 64'd0);
        d_cnt = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (i == 2) rst_n = 1'b1;
            #1;
            if (bus.done === 1'b1 || bus.glob_descriptor_set === 1'b1 || bus.fault === 1'b1) d_cnt++;
        end
        chk("rst_mid/no_pulse", 64'(d_cnt), 64'd0);

        for (int n = 0; n < 40; n++) begin
            int lats[6];
            int ab;
            logic [15:0] sel;
            lats = '{0, 1, 2, 3, 4, 7};
            bus.gdtr_base  = $urandom;
            bus.ldtr_base  = ($urandom_range(0, 3) == 0) ? 32'hFFFFFFF0 : $urandom;
            bus.gdtr_limit = ($urandom_range(0, 2) == 0) ? 16'hFFFF : 16'($urandom_range(0, 63));
            bus.ldtr_limit = ($urandom_range(0, 2) == 0) ? 32'hFFFFFFFF : 32'($urandom_range(0, 63));
            bus.ldtr_valid = ($urandom_range(0, 3) != 0);
            sel = {13'($urandom_range(0, 9)), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3))};
            if ($urandom_range(0, 9) == 0) sel[15:3] = 13'h1FFF;
            ab = ($urandom_range(0, 5) == 0) ? $urandom_range(1, 8) : 0;
            run_fetch($sformatf("rnd%0d", n), sel, 1'($urandom_range(0, 1)),
                      lats[$urandom_range(0, 5)], lats[$urandom_range(0, 5)], ab,
                      ($urandom_range(0, 3) == 0));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
